// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with count, thresholds, error pulses and optional FWFT read
module fifo_sync_param #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic                       r_en,
    input  logic [WIDTH-1:0]           datain,
    output logic [WIDTH-1:0]           dataout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             wa, ra;

    // pointers wrap explicitly so non-power-of-two depths work
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= CW'(AF_THRESH);
    assign almost_empty = count <= CW'(AE_THRESH);
    assign wa           = w_en && !full;
    assign ra           = r_en && !empty;

    // pointer, occupancy and error-pulse state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr      <= wa ? nxt(wptr) : wptr;
            rptr      <= ra ? nxt(rptr) : rptr;
            count     <= count + CW'(wa) - CW'(ra);
            overflow  <= w_en && full;
            underflow <= r_en && empty;
        end
    end

    // storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (wa) mem[wptr] <= datain;
    end

    if (FWFT != 0) begin : g_fwft
        assign dataout = empty ? '0 : mem[rptr];
    end else begin : g_std
        // registered read: word lands one cycle after the accepted read
        always_ff @(posedge clk or posedge rst) begin
            if (rst) dataout <= '0;
            else if (ra) dataout <= mem[rptr];
        end
    end
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: scoreboard bench for three FIFO configurations (16-deep std, 5-deep std, 4-deep FWFT)
module tb_fifo_sync_param;
    logic clk = 1'b0, rst = 1'b0;
    logic [2:0] we = '0, re = '0;
    logic [15:0] di0 = '0, di2 = '0;
    logic [7:0] di1 = '0;
    logic [15:0] d0, d2;
    logic [7:0] d1;
    logic [4:0] c0;
    logic [2:0] c1, c2;
    logic [2:0] fl, em, af, ae, ov, un;

    int dep[3] = '{16, 5, 4};
    int aft[3] = '{14, 3, 3};
    int aet[3] = '{2, 1, 1};
    int fw[3]  = '{0, 0, 1};
    int mc[3]  = '{0, 0, 0};
    logic [15:0] md[3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] q0[$], q1[$], q2[$];
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(.WIDTH(16), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .w_en(we[0]), .r_en(re[0]), .datain(di0), .dataout(d0),
        .full(fl[0]), .empty(em[0]), .almost_full(af[0]), .almost_empty(ae[0]),
        .count(c0), .overflow(ov[0]), .underflow(un[0]));

    fifo_sync_param #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u_b (
        .clk(clk), .rst(rst), .w_en(we[1]), .r_en(re[1]), .datain(di1), .dataout(d1),
        .full(fl[1]), .empty(em[1]), .almost_full(af[1]), .almost_empty(ae[1]),
        .count(c1), .overflow(ov[1]), .underflow(un[1]));

    fifo_sync_param #(.WIDTH(16), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u_c (
        .clk(clk), .rst(rst), .w_en(we[2]), .r_en(re[2]), .datain(di2), .dataout(d2),
        .full(fl[2]), .empty(em[2]), .almost_full(af[2]), .almost_empty(ae[2]),
        .count(c2), .overflow(ov[2]), .underflow(un[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outs(input int k, input logic eo, input logic eu);
        logic [15:0] dv, hd;
        int cv, sz;
        dv = k == 0 ? d0 : k == 1 ? {8'h00, d1} : d2;
        cv = k == 0 ? int'(c0) : k == 1 ? int'(c1) : int'(c2);
        sz = k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
        hd = sz == 0 ? 16'h0 : k == 0 ? q0[0] : k == 1 ? q1[0] : q2[0];
        chk($sformatf("u%0d.count", k), cv, mc[k]);
        chk($sformatf("u%0d.full", k), fl[k], mc[k] == dep[k]);
        chk($sformatf("u%0d.empty", k), em[k], mc[k] == 0);
        chk($sformatf("u%0d.almost_full", k), af[k], mc[k] >= aft[k]);
        chk($sformatf("u%0d.almost_empty", k), ae[k], mc[k] <= aet[k]);
        chk($sformatf("u%0d.overflow", k), ov[k], eo);
        chk($sformatf("u%0d.underflow", k), un[k], eu);
        chk($sformatf("u%0d.dataout", k), dv, fw[k] != 0 ? hd : md[k]);
    endtask

    // drive one request cycle on instance k, update the scoreboard, check after the edge
    task automatic step(input int k, input logic w, input logic r, input logic [15:0] d);
        logic wa, ra, eo, eu;
        logic [15:0] h;
        wa = w && mc[k] < dep[k];
        ra = r && mc[k] > 0;
        eo = w && mc[k] == dep[k];
        eu = r && mc[k] == 0;
        if (ra) begin
            h = k == 0 ? q0.pop_front() : k == 1 ? q1.pop_front() : q2.pop_front();
            if (fw[k] == 0) md[k] = h;
        end
        if (wa) begin
            if (k == 0) q0.push_back(d);
            else if (k == 1) q1.push_back(d);
            else q2.push_back(d);
        end
        mc[k] = mc[k] + int'(wa) - int'(ra);
        we[k] = w;
        re[k] = r;
        di0 = d;
        di1 = d[7:0];
        di2 = d;
        @(posedge clk);
        #1;
        we = '0;
        re = '0;
        check_outs(k, eo, eu);
    endtask

    // asynchronous reset, checked before any clock edge can occur
    task automatic do_rst();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            mc[k] = 0;
            md[k] = '0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
        for (int k = 0; k < 3; k++) check_outs(k, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1;
        do_rst();
        // basic traffic, then reset in the middle of it
        step(0, 1, 0, 16'h0011);
        step(0, 1, 0, 16'h0022);
        step(0, 0, 1, 16'h0);
        step(0, 1, 0, 16'h0033);
        do_rst();
        step(0, 1, 0, 16'h0011);
        step(0, 1, 0, 16'h0022);
        step(0, 1, 0, 16'h0033);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h0);
        // fill past full, drain past empty
        for (int i = 0; i < 17; i++) step(0, 1, 0, 16'h0100 + 16'(i));
        step(0, 0, 0, 16'h0);
        for (int i = 0; i < 17; i++) step(0, 0, 1, 16'h0);
        step(0, 0, 0, 16'h0);
        // simultaneous requests at full and at empty
        for (int i = 0; i < 16; i++) step(0, 1, 0, 16'h0200 + 16'(i));
        step(0, 1, 1, 16'hDEAD);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 16'h0);
        step(0, 1, 1, 16'h0BEE);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 16'h0300 + 16'(i));
        for (int i = 0; i < 20; i++) step(0, 1, 1, 16'($urandom));
        for (int i = 0; i < 8; i++) step(0, 0, 1, 16'h0);
        // non-power-of-two wrap
        for (int i = 0; i < 5; i++) step(1, 1, 0, 16'h0010 + 16'(i));
        step(1, 1, 0, 16'h00EE);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 16'h0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 16'h0020 + 16'(i));
        for (int i = 0; i < 6; i++) step(1, 0, 1, 16'h0);
        for (int i = 0; i < 12; i++) step(1, 1, i % 3 != 0, 16'($urandom_range(0, 255)));
        // first-word-fall-through
        step(2, 1, 0, 16'hABCD);
        step(2, 0, 0, 16'h0);
        step(2, 0, 1, 16'h0);
        step(2, 0, 1, 16'h0);
        for (int i = 0; i < 5; i++) step(2, 1, 0, 16'h0C00 + 16'(i));
        step(2, 1, 1, 16'h0CFF);
        for (int i = 0; i < 4; i++) step(2, 0, 1, 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
